// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts one decoded instruction at a time, reads both
// sources from the register file, and hands the operands to execute.
// A per-register busy scoreboard tracks destination writes that have been
// issued but not yet written back, and blocks RAW/WAW hazards until then.
module operand_fetch #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32,
  parameter int CTRL_W       = 16,
  parameter int RD_TIMEOUT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_LEN-1:0] in_ra,
  input  logic [REG_ADDR_LEN-1:0] in_rb,
  input  logic                    in_use_a,
  input  logic                    in_use_b,
  input  logic [REG_ADDR_LEN-1:0] in_rc,
  input  logic                    in_wr,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic [REG_ADDR_LEN-1:0] ra,
  output logic [REG_ADDR_LEN-1:0] rb,
  output logic                    r_en_A,
  output logic                    r_en_B,
  input  logic [WIDTH-1:0]        dataA,
  input  logic [WIDTH-1:0]        dataB,
  input  logic                    st_A,
  input  logic                    st_B,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_rc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic [REG_ADDR_LEN-1:0] out_rc,
  output logic                    out_wr,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic                    rd_err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    use_a_reg;
  logic                    use_b_reg;
  logic [REG_ADDR_LEN-1:0] rc_reg;
  logic                    wr_reg;
  logic [CTRL_W-1:0]       ctrl_reg;

  logic [NUM_REGS-1:0]     busy_reg;
  logic [NUM_REGS-1:0]     busy_next;
  logic [NUM_REGS-1:0]     set_vec;
  logic [NUM_REGS-1:0]     clr_vec;
  logic [NUM_REGS-1:0]     busy_eff;

  logic out_fire;
  logic hazard;
  logic accept;
  logic rd_ok_a;
  logic rd_ok_b;
  logic timeout;

  // out_valid is only ever high in HOLD, so this is the issue handshake;
  // a flush in the same cycle cancels the issue.
  assign out_fire = out_valid & out_ready & ~flush;

  // Per-register set/clear. Register 0 is hard-wired not busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign set_vec[gi]   = 1'b0;
        assign clr_vec[gi]   = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign set_vec[gi]   = out_fire & out_wr & (out_rc == REG_ADDR_LEN'(gi));
        assign clr_vec[gi]   = wb_en & (wb_rc == REG_ADDR_LEN'(gi));
        // A set in the same cycle as a clear wins.
        assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  // The hazard check sees a destination being issued this cycle, but not a
  // writeback this cycle: the reader is accepted one cycle after the commit.
  assign busy_eff = busy_reg | set_vec;
  assign hazard   = (in_use_a & busy_eff[in_ra]) |
                    (in_use_b & busy_eff[in_rb]) |
                    (in_wr    & busy_eff[in_rc]);

  assign in_ready = rst_n & ~flush & ~hazard &
                    ((state_reg == IDLE) | ((state_reg == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  assign rd_ok_a  = ~use_a_reg | st_A;
  assign rd_ok_b  = ~use_b_reg | st_B;
  assign timeout  = (cnt_reg == CNT_W'(RD_TIMEOUT - 1));

  // Scoreboard of destinations issued but not yet written back.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  // Stage FSM: IDLE -> READ (read ports driven) -> HOLD (operands presented).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      use_a_reg <= 1'b0;
      use_b_reg <= 1'b0;
      rc_reg    <= '0;
      wr_reg    <= 1'b0;
      ctrl_reg  <= '0;
      ra        <= '0;
      rb        <= '0;
      r_en_A    <= 1'b0;
      r_en_B    <= 1'b0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rc    <= '0;
      out_wr    <= 1'b0;
      out_ctrl  <= '0;
      rd_err    <= 1'b0;
    end else if (flush) begin
      // Drop whatever is in flight; scoreboard and rd_err are untouched.
      state_reg <= IDLE;
      r_en_A    <= 1'b0;
      r_en_B    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        READ: begin
          if ((rd_ok_a & rd_ok_b) | timeout) begin
            // A missing strobe at timeout yields a zero operand.
            out_a     <= (use_a_reg & st_A) ? dataA : '0;
            out_b     <= (use_b_reg & st_B) ? dataB : '0;
            out_rc    <= rc_reg;
            out_wr    <= wr_reg;
            out_ctrl  <= ctrl_reg;
            out_valid <= 1'b1;
            r_en_A    <= 1'b0;
            r_en_B    <= 1'b0;
            state_reg <= HOLD;
            if (!(rd_ok_a & rd_ok_b)) rd_err <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: ;
      endcase

      // Accept only happens in IDLE or on the HOLD handshake, so this
      // cleanly overrides the state chosen above.
      if (accept) begin
        ra        <= in_ra;
        rb        <= in_rb;
        r_en_A    <= in_use_a;
        r_en_B    <= in_use_b;
        use_a_reg <= in_use_a;
        use_b_reg <= in_use_b;
        rc_reg    <= in_rc;
        wr_reg    <= in_wr;
        ctrl_reg  <= in_ctrl;
        cnt_reg   <= '0;
        state_reg <= READ;
      end
    end
  end

endmodule
